// File: rtl/wb_arbiter2_pkg.sv
// Shared types and bus widths for the wb_arbiter2 two-master Wishbone arbiter.
package wb_arbiter2_pkg;

   localparam int WB_ADR_W = 16;
   localparam int WB_DAT_W = 16;
   localparam int BURST_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational round-robin selector: with both masters requesting, the one
// that was not served last wins; a lone requester always wins.
module wb_arb_pick
   import wb_arbiter2_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   // One-hot grant from the request pair and the last-served pointer
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter, round-robin with preemption
// after MAX_BURST acks. Optional stall watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_arbiter2
   import wb_arbiter2_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                m0_cyc_i,
   input  logic                m0_stb_i,
   input  logic                m0_we_i,
   input  logic [WB_ADR_W-1:0] m0_adr_i,
   input  logic [WB_DAT_W-1:0] m0_dat_w_i,
   output logic [WB_DAT_W-1:0] m0_dat_r_o,
   output logic                m0_ack_o,
   output logic                m0_err_o,
   input  logic                m1_cyc_i,
   input  logic                m1_stb_i,
   input  logic                m1_we_i,
   input  logic [WB_ADR_W-1:0] m1_adr_i,
   input  logic [WB_DAT_W-1:0] m1_dat_w_i,
   output logic [WB_DAT_W-1:0] m1_dat_r_o,
   output logic                m1_ack_o,
   output logic                m1_err_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [WB_ADR_W-1:0] s_adr_o,
   output logic [WB_DAT_W-1:0] s_dat_w_o,
   input  logic [WB_DAT_W-1:0] s_dat_r_i,
   input  logic                s_ack_i
);

   localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

   arb_state_t          state_q, state_d;
   logic                last_q, last_d;
   logic [BURST_W-1:0]  burst_q, burst_d;

   logic                granted_s, sel1_s;
   logic                cyc_x_s, stb_x_s, we_x_s, other_cyc_s;
   logic [WB_ADR_W-1:0] adr_x_s;
   logic [WB_DAT_W-1:0] dat_w_x_s;
   logic [1:0]          req_s, gnt_s;
   logic                pick_last_s, preempt_s, wd_fire_s;

   assign granted_s   = (state_q != IDLE);
   assign sel1_s      = (state_q == GNT1);
   assign cyc_x_s     = sel1_s ? m1_cyc_i   : m0_cyc_i;
   assign stb_x_s     = sel1_s ? m1_stb_i   : m0_stb_i;
   assign we_x_s      = sel1_s ? m1_we_i    : m0_we_i;
   assign adr_x_s     = sel1_s ? m1_adr_i   : m0_adr_i;
   assign dat_w_x_s   = sel1_s ? m1_dat_w_i : m0_dat_w_i;
   assign other_cyc_s = sel1_s ? m0_cyc_i   : m1_cyc_i;

   // While granted the current owner counts as last-served, so the picker
   // hands over to the other master at exit and preemption points.
   assign req_s       = {m1_cyc_i, m0_cyc_i};
   assign pick_last_s = granted_s ? sel1_s : last_q;

   wb_arb_pick u_pick (
      .req_i  (req_s),
      .last_i (pick_last_s),
      .gnt_o  (gnt_s)
   );

   assign preempt_s = (MAX_B != {BURST_W{1'b0}}) && s_ack_i && other_cyc_s &&
                      ((burst_q + ONE_B) == MAX_B);

`ifdef WB_ARB_TIMEOUT_EN
   localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   logic [WD_W-1:0] wd_q, wd_d;

   assign wd_fire_s = granted_s && stb_x_s && (wd_q == WD_LAST);

   // Stall counter: cycles with strobe high and no ack under the same grant
   always_comb begin
      wd_d = wd_q;
      if (!granted_s || s_ack_i || (state_d != state_q)) begin
         wd_d = {WD_W{1'b0}};
      end else if (stb_x_s) begin
         wd_d = wd_q + WD_ONE;
      end else begin
         wd_d = wd_q;
      end
   end

   // Watchdog register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wd_q <= {WD_W{1'b0}};
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT != 0);
   assign wd_fire_s        = 1'b0;
`endif

   // Slave-side mux and master responses, all combinational from the grant
   always_comb begin
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_adr_o    = {WB_ADR_W{1'b0}};
      s_dat_w_o  = {WB_DAT_W{1'b0}};
      m0_ack_o   = 1'b0;
      m1_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m1_err_o   = 1'b0;
      m0_dat_r_o = {WB_DAT_W{1'b0}};
      m1_dat_r_o = {WB_DAT_W{1'b0}};
      if (granted_s) begin
         s_cyc_o    = cyc_x_s;
         s_stb_o    = stb_x_s & ~wd_fire_s;
         s_we_o     = we_x_s;
         s_adr_o    = adr_x_s;
         s_dat_w_o  = dat_w_x_s;
         m0_ack_o   = ~sel1_s & s_ack_i & ~wd_fire_s;
         m1_ack_o   =  sel1_s & s_ack_i & ~wd_fire_s;
         m0_err_o   = ~sel1_s & wd_fire_s;
         m1_err_o   =  sel1_s & wd_fire_s;
         m0_dat_r_o = s_dat_r_i;
         m1_dat_r_o = s_dat_r_i;
      end else begin
         s_we_o     = 1'b0;
      end
   end

   // Next grant, last-served pointer and burst counter
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            burst_d = {BURST_W{1'b0}};
            if (gnt_s[0]) begin
               state_d = GNT0;
            end else if (gnt_s[1]) begin
               state_d = GNT1;
            end else begin
               state_d = IDLE;
            end
         end
         GNT0, GNT1: begin
            if (wd_fire_s) begin
               state_d = IDLE;
            end else if (!cyc_x_s || preempt_s) begin
               case (gnt_s)
                  2'b01:   state_d = GNT0;
                  2'b10:   state_d = GNT1;
                  default: state_d = IDLE;
               endcase
            end else begin
               state_d = state_q;
            end
            if (state_d != state_q) begin
               last_d  = sel1_s;
               burst_d = {BURST_W{1'b0}};
            end else if (!other_cyc_s) begin
               burst_d = {BURST_W{1'b0}};
            end else if (s_ack_i && (burst_q != MAX_B)) begin
               burst_d = burst_q + ONE_B;
            end else begin
               burst_d = burst_q;
            end
         end
         default: begin
            state_d = IDLE;
            burst_d = {BURST_W{1'b0}};
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         burst_q <= {BURST_W{1'b0}};
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2: u_a uses MAX_BURST=4, u_b uses
// MAX_BURST=0; both see the same master stimulus and a bench-driven slave.
module tb_wb_arbiter2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [15:0] m0_adr, m0_dat_w, m1_adr, m1_dat_w;
   logic        ack_auto, ack_man;

   logic [15:0] a_m0_dat_r, a_m1_dat_r, a_s_adr, a_s_dat_w, a_s_dat_r;
   logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we, a_s_ack;
   logic [15:0] b_m0_dat_r, b_m1_dat_r, b_s_adr, b_s_dat_w, b_s_dat_r;
   logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we, b_s_ack;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign a_s_ack   = ack_auto ? (a_s_cyc & a_s_stb) : ack_man;
   assign b_s_ack   = ack_auto ? (b_s_cyc & b_s_stb) : ack_man;
   assign a_s_dat_r = a_s_adr ^ 16'hA5A5;
   assign b_s_dat_r = b_s_adr ^ 16'hA5A5;

   wb_arbiter2 #(.MAX_BURST(4), .TIMEOUT(8)) u_a (
      .clk_i(clk), .reset_ni(reset_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_dat_w_i(m0_dat_w), .m0_dat_r_o(a_m0_dat_r), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_dat_w_i(m1_dat_w), .m1_dat_r_o(a_m1_dat_r), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
      .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
      .s_dat_w_o(a_s_dat_w), .s_dat_r_i(a_s_dat_r), .s_ack_i(a_s_ack)
   );

   wb_arbiter2 #(.MAX_BURST(0), .TIMEOUT(8)) u_b (
      .clk_i(clk), .reset_ni(reset_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_dat_w_i(m0_dat_w), .m0_dat_r_o(b_m0_dat_r), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_dat_w_i(m1_dat_w), .m1_dat_r_o(b_m1_dat_r), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
      .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
      .s_dat_w_o(b_s_dat_w), .s_dat_r_i(b_s_dat_r), .s_ack_i(b_s_ack)
   );

   task automatic zero_inputs();
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 16'h0000; m0_dat_w = 16'h0000;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 16'h0000; m1_dat_w = 16'h0000;
      ack_auto = 1'b0; ack_man = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      zero_inputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 16'h1234; m0_dat_w = 16'hBEEF;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 16'h4321; m1_dat_w = 16'hCAFE;
      ack_auto = 1'b0; ack_man = 1'b1;
      #7;
      n_chk++;
      if ({a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err} !== 7'b0) begin
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err});
      end else n_pass++;
      n_chk++;
      if ({a_s_adr, a_s_dat_w} !== 32'h0) begin
         $display("FAIL reset_sbus: adr=%h dat_w=%h want 0", a_s_adr, a_s_dat_w);
      end else n_pass++;
      n_chk++;
      if ({a_m0_dat_r, a_m1_dat_r} !== 32'h0) begin
         $display("FAIL reset_dat_r: m0=%h m1=%h want 0", a_m0_dat_r, a_m1_dat_r);
      end else n_pass++;
   endtask

   task automatic test_single_master();
      logic e_ack;
      do_reset();
      ack_auto = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = k[0];
         m0_adr = 16'h1000 + 16'(k); m0_dat_w = 16'h2000 + 16'(k);
         #1;
         e_ack = (k >= 2);
         n_chk++;
         if ({a_m0_ack, a_m1_ack} !== {e_ack, 1'b0}) begin
            $display("FAIL single_ack k=%0d: got m0=%b m1=%b want m0=%b m1=0", k, a_m0_ack, a_m1_ack, e_ack);
         end else n_pass++;
         if (k >= 2) begin
            n_chk++;
            if ({a_s_adr, a_s_dat_w, a_s_we, a_m0_dat_r} !== {m0_adr, m0_dat_w, m0_we, m0_adr ^ 16'hA5A5}) begin
               $display("FAIL single_mux k=%0d: adr=%h dw=%h we=%b dr=%h want %h %h %b %h", k,
                        a_s_adr, a_s_dat_w, a_s_we, a_m0_dat_r, m0_adr, m0_dat_w, m0_we, m0_adr ^ 16'hA5A5);
            end else n_pass++;
         end
      end
   endtask

   task automatic test_round_robin();
      logic e0, e1;
      do_reset();
      ack_auto = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0A00 + 16'(k);
         m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h0B00 + 16'(k);
         #1;
         e0 = (k >= 2) && ((((k - 2) / 4) % 2) == 0);
         e1 = (k >= 2) && !e0;
         n_chk++;
         if ({a_m0_ack, a_m1_ack} !== {e0, e1}) begin
            $display("FAIL rr_ack k=%0d: got m0=%b m1=%b want m0=%b m1=%b", k, a_m0_ack, a_m1_ack, e0, e1);
         end else n_pass++;
         if (k >= 2) begin
            n_chk++;
            if (a_s_adr !== (e0 ? m0_adr : m1_adr)) begin
               $display("FAIL rr_adr k=%0d: got %h want %h", k, a_s_adr, e0 ? m0_adr : m1_adr);
            end else n_pass++;
         end
      end
   endtask

   task automatic test_no_preempt();
      do_reset();
      ack_auto = 1'b1;
      m0_adr = 16'h00C0; m1_adr = 16'h00D0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
         #1;
         n_chk++;
         if ({b_m0_ack, b_m1_ack} !== {(k >= 2), 1'b0}) begin
            $display("FAIL nopre_hold k=%0d: got m0=%b m1=%b want m0=%b m1=0", k, b_m0_ack, b_m1_ack, (k >= 2));
         end else n_pass++;
      end
      @(negedge clk);
      m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      n_chk++;
      if ({b_s_cyc, b_m1_ack} !== 2'b00) begin
         $display("FAIL nopre_drop: s_cyc=%b m1_ack=%b want 0 0", b_s_cyc, b_m1_ack);
      end else n_pass++;
      @(negedge clk);
      #1;
      n_chk++;
      if ({b_m1_ack, b_s_adr} !== {1'b1, m1_adr}) begin
         $display("FAIL nopre_m1: m1_ack=%b adr=%h want 1 %h", b_m1_ack, b_s_adr, m1_adr);
      end else n_pass++;
      @(negedge clk);
      m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      n_chk++;
      if ({b_m0_ack, b_m1_ack} !== 2'b01) begin
         $display("FAIL nopre_keep: m0=%b m1=%b want 0 1", b_m0_ack, b_m1_ack);
      end else n_pass++;
      @(negedge clk);
      m1_cyc = 1'b0; m1_stb = 1'b0;
      #1;
      n_chk++;
      if ({b_s_cyc, b_m0_ack, b_m1_ack} !== 3'b000) begin
         $display("FAIL b2b_gap: cyc=%b m0=%b m1=%b want 000", b_s_cyc, b_m0_ack, b_m1_ack);
      end else n_pass++;
      @(negedge clk);
      m1_cyc = 1'b1; m1_stb = 1'b1;
      #1;
      n_chk++;
      if ({b_m0_ack, b_m1_ack, b_s_adr} !== {2'b10, m0_adr}) begin
         $display("FAIL b2b_regrant: m0=%b m1=%b adr=%h want 1 0 %h", b_m0_ack, b_m1_ack, b_s_adr, m0_adr);
      end else n_pass++;
   endtask

   task automatic test_wait_states();
      logic [15:0] pat;
      pat = 16'b0000_1001_1010_0000;
      do_reset();
      m0_adr = 16'h0E00; m1_adr = 16'h0F00;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
         ack_man = pat[k];
         #1;
         if (k >= 2) begin
            n_chk++;
            if (a_s_adr !== ((k == 12) ? m1_adr : m0_adr)) begin
               $display("FAIL wait_adr k=%0d: got %h want %h", k, a_s_adr, (k == 12) ? m1_adr : m0_adr);
            end else n_pass++;
            n_chk++;
            if ({a_m0_ack, a_m1_ack} !== {(pat[k] && (k < 12)), 1'b0}) begin
               $display("FAIL wait_ack k=%0d: got m0=%b m1=%b want m0=%b m1=0", k, a_m0_ack, a_m1_ack,
                        (pat[k] && (k < 12)));
            end else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ack_auto = 1'b1;
      m0_adr = 16'h0100; m1_adr = 16'h0200;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      end
      #1;
      n_chk++;
      if (a_m1_ack !== 1'b1) begin
         $display("FAIL rstmid_pre: m1_ack=%b want 1", a_m1_ack);
      end else n_pass++;
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      n_chk++;
      if ({a_s_cyc, a_s_stb, a_m0_ack, a_m1_ack} !== 4'b0000) begin
         $display("FAIL rstmid_async: cyc=%b stb=%b m0=%b m1=%b want 0000", a_s_cyc, a_s_stb, a_m0_ack, a_m1_ack);
      end else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_chk++;
      if (a_s_cyc !== 1'b0) begin
         $display("FAIL rstmid_idle: s_cyc=%b want 0", a_s_cyc);
      end else n_pass++;
      @(negedge clk);
      #1;
      n_chk++;
      if ({a_m0_ack, a_m1_ack, a_s_adr} !== {2'b10, m0_adr}) begin
         $display("FAIL rstmid_first: m0=%b m1=%b adr=%h want 1 0 %h", a_m0_ack, a_m1_ack, a_s_adr, m0_adr);
      end else n_pass++;
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      m0_adr = 16'h0300; m1_adr = 16'h0400;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         m1_cyc = 1'b1; m1_stb = 1'b1;
         if (k >= 3) begin
            m0_cyc = 1'b1; m0_stb = 1'b1;
         end
         #1;
         if (k >= 2 && k <= 8) begin
            n_chk++;
            if ({a_m1_err, a_s_stb, a_m1_ack} !== 3'b010) begin
               $display("FAIL to_stall k=%0d: err=%b stb=%b ack=%b want 0 1 0", k, a_m1_err, a_s_stb, a_m1_ack);
            end else n_pass++;
         end else if (k == 9) begin
            n_chk++;
            if ({a_m1_err, a_s_stb, a_m1_ack, a_m0_err} !== 4'b1000) begin
               $display("FAIL to_fire: err=%b stb=%b ack=%b m0err=%b want 1 0 0 0", a_m1_err, a_s_stb, a_m1_ack, a_m0_err);
            end else n_pass++;
         end else if (k == 10) begin
            n_chk++;
            if ({a_s_cyc, a_m1_err} !== 2'b00) begin
               $display("FAIL to_idle: cyc=%b err=%b want 0 0", a_s_cyc, a_m1_err);
            end else n_pass++;
         end else if (k == 11) begin
            n_chk++;
            if ({a_s_adr, a_s_stb} !== {m0_adr, 1'b1}) begin
               $display("FAIL to_regrant: adr=%h stb=%b want %h 1", a_s_adr, a_s_stb, m0_adr);
            end else n_pass++;
         end
      end
   endtask
`endif

   initial begin
      zero_inputs();
      reset_n = 1'b0;
      test_reset();
      test_single_master();
      test_round_robin();
      test_no_preempt();
      test_wait_states();
      test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
